mcu_gpio_fabric_port: RTL
=========================

// Module: mcu_gpio_fabric_port
// PURPOSE
//  Fabric-side endpoint of the MCU hard-block high GPIO bank (gpio_h_*). Takes the MCU's
//  gpio_h_out / gpio_h_oe_n, resynchronises them and drives the pad buffers. In the other
//  direction it synchronises and debounces the pad inputs and returns them on gpio_h_in.
//  It also raises one-cycle rise and fall event pulses for fabric logic. It sits between
//  the mcu wrapper and the top-level tri-state pad instances.
// PARAMETERS
//  WIDTH         4   number of GPIO lines handled (1..16)
//  SYNC_STAGES   2   flops in every CDC synchroniser (>=2)
//  DEBOUNCE_CYC  16  consecutive clk cycles an input must differ before accepted (>=1; 1 = no debounce)
// PORTS
//  clk           in   1      fabric clock
//  rstn          in   1      reset, asynchronous, active-low
//  mcu_out       in   WIDTH  from MCU gpio_h_out (asynchronous to clk)
//  mcu_oe_n      in   WIDTH  from MCU gpio_h_oe_n, 0 = drive (asynchronous to clk)
//  mcu_in        out  WIDTH  to MCU gpio_h_in: debounced pad state
//  pad_in        in   WIDTH  raw pad input buffers
//  pad_out       out  WIDTH  pad output data
//  pad_oe        out  WIDTH  pad output enable, 1 = drive
//  edge_rise     out  WIDTH  1-cycle pulse per bit on accepted 0->1 of mcu_in
//  edge_fall     out  WIDTH  1-cycle pulse per bit on accepted 1->0 of mcu_in
// BEHAVIOUR
//  Reset (rstn=0, async): all output outputs go low: mcu_in=0, pad_out=0, pad_oe=0 (pads tri-stated),
//   edge_rise=0, edge_fall=0. Input syncs and debounce counters reset to 0. mcu_oe_n syncs reset to 1.
//  Output path: mcu_out and mcu_oe_n each pass through a SYNC_STAGES synchroniser.
//   pad_out and pad_oe = ~oe_sync are registered off the last stage.
//   Latency is SYNC_STAGES+1 clk edges. pad_out and pad_oe update on the same edge (no skew).
//  Input path, per bit: pad_in passes through a SYNC_STAGES synchroniser to give s.
//   Each bit holds an accepted state a (drives mcu_in) and a counter cnt, width $clog2(DEBOUNCE_CYC)+1.
//   s==a: cnt<=0.
//   s!=a and cnt<DEBOUNCE_CYC-1: cnt<=cnt+1.
//   s!=a and cnt==DEBOUNCE_CYC-1: a<=s and cnt<=0.
//   Result: a clean pad step reaches mcu_in after SYNC_STAGES+DEBOUNCE_CYC edges.
//   A glitch shorter than DEBOUNCE_CYC synced cycles restarts the count and is never accepted.
//  Edges: edge_rise/edge_fall are registered and asserted in exactly the cycle mcu_in first shows
//   the new value. They are high for one cycle only and can never both be high on one bit.
//  Bits are fully independent. Simultaneous changes on several bits give simultaneous pulses.
//  Counter saturation: cnt never exceeds DEBOUNCE_CYC-1. There is no wrap.
//  Reset mid-debounce: the count is discarded and mcu_in returns to 0. After release a pad held
//   at 1 is re-accepted after the full SYNC_STAGES+DEBOUNCE_CYC edges and yields one edge_rise.
//  No combinational path from any input to any output.
// STRUCTURE
//  Package mcu_gpio_pkg holds:
//   - the parameter defaults MCU_GPIO_MAX_WIDTH=16 and MCU_GPIO_DEF_DEBOUNCE=16
//   - the counter width function
//  Sub-module mcu_gpio_in_filter holds one bit of synchroniser, debounce counter, accepted flop and
//   edge pulses. It is instantiated WIDTH times in a generate loop. The output-path synchronisers
//   stay in the top module.
// TESTING (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYC=4)
//  1 Reset: hold rstn=0 with random inputs. Required: pad_oe=0, pad_out=0, mcu_in=0, no edge pulses.
//    Deassert rstn with all pins static. Required: still no pulses.
//  2 Clean rise: pad_in[0] steps 0->1 at edge 0. Required: mcu_in[0]=1 after edge 6 and edge_rise[0]
//    high for exactly that one cycle. Then step it back 1->0. Required: edge_fall[0] after 6 edges.
//  3 Glitch reject: pad_in[1] held high 3 cycles, then low. Required: mcu_in[1] stays 0 with no pulses.
//    Then hold it high 4 cycles. Required: it is accepted.
//  4 Output path: mcu_oe_n=4'b1010, mcu_out=4'b0101. Required: pad_oe=4'b0101, pad_out=4'b0101,
//    both appearing together 3 edges later.
//  5 Reset mid-count: pad_in[2]=1, assert rstn after 3 cycles, release. Required: mcu_in[2]=0
//    during reset, then 1 with a single edge_rise[2] 6 edges after release.
//  6 Independence: pad_in=4'b1111 all at once. Required: 4 simultaneous edge_rise bits, identical latency.

Source files
------------

// File: rtl/mcu_gpio_pkg.sv
// Shared defaults and helpers for the MCU high GPIO bank fabric port.
package mcu_gpio_pkg;

    // Widest GPIO bank the fabric port is meant to serve
    localparam int MCU_GPIO_MAX_WIDTH    = 16;
    // Default number of stable clk cycles before a pad change is accepted
    localparam int MCU_GPIO_DEF_DEBOUNCE = 16;
    // Default CDC synchroniser depth
    localparam int MCU_GPIO_DEF_SYNC     = 2;

    // Debounce counter width. One spare bit above $clog2 keeps the count
    // representable even when DEBOUNCE_CYC is a power of two or equals 1.
    function automatic int gpio_cnt_width(input int debounce_cyc);
        return $clog2(debounce_cyc) + 32'sd1;
    endfunction

endpackage

// File: rtl/mcu_gpio_in_filter.sv
// One GPIO input bit: CDC synchroniser, debounce counter, accepted state and
// registered rise/fall event pulses aligned with the accepted state change.
module mcu_gpio_in_filter
    import mcu_gpio_pkg::*;
#(
    parameter int SYNC_STAGES  = MCU_GPIO_DEF_SYNC,
    parameter int DEBOUNCE_CYC = MCU_GPIO_DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic rstn,
    input  logic pad_in,
    output logic acc,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W   = gpio_cnt_width(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   acc_r;
    logic                   acc_nxt_s;
    logic                   rise_r;
    logic                   rise_nxt_s;
    logic                   fall_r;
    logic                   fall_nxt_s;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Debounce decision: count consecutive disagreeing samples, flip on the last one
    always_comb begin
        cnt_nxt_s  = '0;
        acc_nxt_s  = acc_r;
        rise_nxt_s = 1'b0;
        fall_nxt_s = 1'b0;
        if (sync_s == acc_r) begin
            cnt_nxt_s = '0;
        end else if (cnt_r >= CNT_MAX) begin
            // Comparing with >= keeps the counter saturated even from a corrupted value
            cnt_nxt_s  = '0;
            acc_nxt_s  = sync_s;
            rise_nxt_s = sync_s;
            fall_nxt_s = ~sync_s;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Synchroniser chain, counter, accepted state and event pulse registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_r <= '0;
            cnt_r  <= '0;
            acc_r  <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pad_in};
            cnt_r  <= cnt_nxt_s;
            acc_r  <= acc_nxt_s;
            rise_r <= rise_nxt_s;
            fall_r <= fall_nxt_s;
        end
    end

    assign acc  = acc_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/mcu_gpio_fabric_port.sv
// Fabric-side endpoint of the MCU high GPIO bank. Resynchronises the MCU
// output/enable lines onto the pad buffers and returns debounced pad inputs
// plus per-bit rise/fall event pulses. Every output is a flop.
module mcu_gpio_fabric_port
    import mcu_gpio_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int SYNC_STAGES  = MCU_GPIO_DEF_SYNC,
    parameter int DEBOUNCE_CYC = MCU_GPIO_DEF_DEBOUNCE
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] mcu_out,
    input  logic [WIDTH-1:0] mcu_oe_n,
    output logic [WIDTH-1:0] mcu_in,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    output logic [WIDTH-1:0] edge_rise,
    output logic [WIDTH-1:0] edge_fall
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] out_sync_r;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] oe_sync_r;
    logic [WIDTH-1:0]                  pad_out_r;
    logic [WIDTH-1:0]                  pad_oe_r;

    // Output path: data and enable share one synchroniser depth so they reach
    // the pads on the same edge; enable syncs reset to "not driving"
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_sync_r <= '0;
            oe_sync_r  <= '1;
            pad_out_r  <= '0;
            pad_oe_r   <= '0;
        end else begin
            out_sync_r[0] <= mcu_out;
            oe_sync_r[0]  <= mcu_oe_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                out_sync_r[i] <= out_sync_r[i-1];
                oe_sync_r[i]  <= oe_sync_r[i-1];
            end
            pad_out_r <= out_sync_r[SYNC_STAGES-1];
            pad_oe_r  <= ~oe_sync_r[SYNC_STAGES-1];
        end
    end

    assign pad_out = pad_out_r;
    assign pad_oe  = pad_oe_r;

    // Input path: one independent filter per GPIO line
    for (genvar g = 0; g < WIDTH; g++) begin : g_in
        mcu_gpio_in_filter #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_filter (
            .clk    (clk),
            .rstn   (rstn),
            .pad_in (pad_in[g]),
            .acc    (mcu_in[g]),
            .rise   (edge_rise[g]),
            .fall   (edge_fall[g])
        );
    end

endmodule
